// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned RF_DW = 32;
  localparam int unsigned RF_AW = 5;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for multi-cycle producers, with write-bypass masking on lookup.
module regfile_scoreboard #(
  parameter int unsigned AW = 5,
  parameter int unsigned NR = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic                   rsv,
  input  logic [AW-1:0]          rsv_a,
  input  logic [NR-1:0][AW-1:0]  ra,
  output logic [NR-1:0]          busy
);

  localparam int unsigned Depth = 2 ** AW;

  logic [Depth-1:0] busy_q, busy_d;

  // Set beats clear so a new producer reserving the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (we)  busy_d[wa]    = 1'b0;
    if (rsv) busy_d[rsv_a] = 1'b1;
  end

  // Busy bits clear asynchronously on reset; we/rsv arrive pre-gated by the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookup per port; a same-cycle write releases the register unless it is re-reserved.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NR; i++) begin
      busy[i] = busy_q[ra[i]] &&
                !(we && (wa == ra[i]) && !(rsv && (rsv_a == ra[i])));
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with zero register, write bypass,
// busy scoreboard and a post-reset clear sweep over the storage array.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned NR       = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NR-1:0][AW-1:0] RA,
  output logic [NR-1:0][DW-1:0] RD,
  output logic [NR-1:0]         RD_BUSY,
  input  logic                  WE3,
  input  logic [AW-1:0]         A3,
  input  logic [DW-1:0]         WD3,
  input  logic                  RSV,
  input  logic [AW-1:0]         RSV_A,
  output logic                  READY
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] LastIdx = (AW+1)'(Depth - 1);
  localparam bit ZeroEn = (ZERO_REG != 0);

  rf_state_e   state_q, state_d;
  logic [AW:0] idx_q, idx_d;
  logic        run;

  logic          we_eff, rsv_eff;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem [Depth];

  assign run = (state_q == ST_RUN);

  // Writes and reserves only take effect in run, and never touch r0 when it is hardwired.
  assign we_eff  = run && WE3 && !(ZeroEn && (A3 == '0));
  assign rsv_eff = run && RSV && !(ZeroEn && (RSV_A == '0));

  // State and sweep index; reset restarts the sweep from entry 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep advances one entry per edge and hands over to run after the last entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) state_d = ST_RUN;
      end
      ST_RUN: begin
        idx_d = idx_q;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Outputs of the sweep FSM: ready flag and the array write port selection.
  always_comb begin
    READY  = run;
    mem_we = we_eff;
    mem_wa = A3;
    mem_wd = WD3;
    if (!run) begin
      mem_we = 1'b1;
      mem_wa = idx_q[AW-1:0];
      mem_wd = '0;
    end
  end

  // Storage has no reset so it can map onto RAM; the sweep initialises it.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Combinational read ports: zero register, then bypass, then storage.
  always_comb begin
    RD = '0;
    for (int i = 0; i < NR; i++) begin
      if (!run || (ZeroEn && (RA[i] == '0))) begin
        RD[i] = '0;
      end else if (we_eff && (A3 == RA[i])) begin
        RD[i] = WD3;
      end else begin
        RD[i] = mem[RA[i]];
      end
    end
  end

  regfile_scoreboard #(
    .AW (AW),
    .NR (NR)
  ) u_scoreboard (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (we_eff),
    .wa    (A3),
    .rsv   (rsv_eff),
    .rsv_a (RSV_A),
    .ra    (RA),
    .busy  (RD_BUSY)
  );

endmodule
